// File: rtl/npc_pkg.sv
// Shared NPC definitions: fetch defaults and IFU state encoding.
// Imported by the fetch unit and later pipeline stages.
package npc_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT
  } ifu_state_e;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding memory read at a time,
// registered offer to decode, redirects drop any in-flight response.
module ifu
  import npc_pkg::*;
#(
  parameter int XLEN = npc_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(npc_pkg::RESET_PC)
) (
  input  logic            clock,
  input  logic            reset,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     fetch_cnt
);

  localparam logic [XLEN-1:0] STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);

  ifu_state_e      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] pc_next;
  logic            drop;

  assign redir_pc = redirect_pc & ALIGN;
  assign pc_next  = pc + STEP;

  // Fetch FSM with pc, drop bookkeeping and all registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      target     <= '0;
      drop       <= 1'b0;
      req_valid  <= 1'b0;
      req_addr   <= '0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      fetch_cnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state     <= S_REQ;
          req_valid <= 1'b1;
          if (redirect_valid) begin
            pc       <= redir_pc;
            req_addr <= redir_pc;
          end else begin
            req_addr <= pc;
          end
        end
        S_REQ: begin
          if (redirect_valid) begin
            drop   <= 1'b1;
            target <= redir_pc;
          end
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            drop   <= 1'b1;
            target <= redir_pc;
          end
          if (resp_valid) begin
            if (drop || redirect_valid) begin
              drop      <= 1'b0;
              state     <= S_REQ;
              req_valid <= 1'b1;
              pc        <= redirect_valid ? redir_pc : target;
              req_addr  <= redirect_valid ? redir_pc : target;
            end else begin
              inst       <= resp_data;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              state      <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (redirect_valid) begin
            pc         <= redir_pc;
            req_addr   <= redir_pc;
            inst_valid <= 1'b0;
            req_valid  <= 1'b1;
            state      <= S_REQ;
          end else if (inst_ready) begin
            pc         <= pc_next;
            req_addr   <= pc_next;
            inst_valid <= 1'b0;
            req_valid  <= 1'b1;
            fetch_cnt  <= fetch_cnt + 32'd1;
            state      <= S_REQ;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Bench for the fetch unit: directed scenarios plus a randomized
// run against a transaction-level fetch model.
module tb_ifu;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] fetch_cnt;

  int vectors = 0;
  int errors  = 0;

  ifu dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_data      = '0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle_inputs();
    resp_valid = 1'b1;
    resp_data  = 32'hFFFF_FFFF;
    tick();
    tick();
    vectors++;
    if (req_valid !== 1'b0)
      $display("FAIL rst_req_valid: got %b want 0", req_valid);
    if (req_valid !== 1'b0) errors++;
    vectors++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_inst_valid: got %b want 0", inst_valid);
    end
    vectors++;
    if (req_addr !== 32'h0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_regs: addr %h inst %h pc %h want 0",
               req_addr, inst, inst_pc);
    end
    vectors++;
    if (fetch_cnt !== 32'h0) begin
      errors++;
      $display("FAIL rst_cnt: got %h want 0", fetch_cnt);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (req_valid !== 1'b1 || req_addr !== RPC || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_first_req: v %b addr %h iv %b want 1 %h 0",
               req_valid, req_addr, inst_valid, RPC);
    end
    idle_inputs();
  endtask

  task automatic test_stream;
    logic [31:0] addrs[3];
    int n;
    int acc;
    n   = 0;
    acc = 0;
    do_reset();
    req_ready  = 1'b1;
    resp_valid = 1'b1;
    resp_data  = 32'h0000_0013;
    inst_ready = 1'b1;
    for (int c = 0; c < 40 && acc < 3; c++) begin
      tick();
      if (req_valid === 1'b1 && n < 3) begin
        addrs[n] = req_addr;
        n++;
      end
      if (inst_valid === 1'b1) acc++;
    end
    vectors++;
    if (acc != 3 || n != 3) begin
      errors++;
      $display("FAIL stream_timeout: accepts %0d reqs %0d want 3 3", acc, n);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (i < n && addrs[i] !== RPC + 32'(4 * i)) begin
        errors++;
        $display("FAIL stream_addr%0d: got %h want %h",
                 i, addrs[i], RPC + 32'(4 * i));
      end
    end
    tick();
    vectors++;
    if (fetch_cnt !== 32'd3) begin
      errors++;
      $display("FAIL stream_cnt: got %0d want 3", fetch_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_slow_resp;
    do_reset();
    req_ready = 1'b1;
    tick();
    tick();
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL slow_wait%0d: req %b inst_v %b want 0 0",
                 i, req_valid, inst_valid);
      end
    end
    resp_valid = 1'b1;
    resp_data  = 32'h0010_0073;
    tick();
    resp_valid = 1'b0;
    resp_data  = '0;
    vectors++;
    if (inst_valid !== 1'b1 || inst !== 32'h0010_0073 || inst_pc !== RPC) begin
      errors++;
      $display("FAIL slow_offer: v %b inst %h pc %h want 1 00100073 %h",
               inst_valid, inst, inst_pc, RPC);
    end
    idle_inputs();
  endtask

  task automatic test_backpressure;
    logic [31:0] held;
    do_reset();
    req_ready  = 1'b1;
    resp_valid = 1'b1;
    resp_data  = 32'h1234_5678;
    tick();
    tick();
    tick();
    resp_data = 32'hAAAA_5555;
    held = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (inst_valid !== 1'b1 || inst !== held || inst_pc !== RPC ||
          req_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: iv %b inst %h pc %h rv %b want 1 %h %h 0",
                 i, inst_valid, inst, inst_pc, req_valid, held, RPC);
      end
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    vectors++;
    if (req_valid !== 1'b1 || req_addr !== RPC + 32'd4 ||
        inst_valid !== 1'b0 || fetch_cnt !== 32'd1) begin
      errors++;
      $display("FAIL bp_release: rv %b addr %h iv %b cnt %0d want 1 %h 0 1",
               req_valid, req_addr, inst_valid, fetch_cnt, RPC + 32'd4);
    end
    idle_inputs();
  endtask

  task automatic test_redirect_wait;
    do_reset();
    req_ready = 1'b1;
    tick();
    tick();
    req_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    resp_valid     = 1'b1;
    resp_data      = 32'hDEAD_BEEF;
    tick();
    resp_valid = 1'b0;
    vectors++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b1 ||
        req_addr !== 32'h8000_0100) begin
      errors++;
      $display("FAIL redir_wait: iv %b rv %b addr %h want 0 1 80000100",
               inst_valid, req_valid, req_addr);
    end
    req_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_wait_drop: iv %b want 0", inst_valid);
    end
    idle_inputs();
  endtask

  task automatic test_redirect_out;
    do_reset();
    req_ready  = 1'b1;
    resp_valid = 1'b1;
    resp_data  = 32'h0000_0013;
    tick();
    tick();
    tick();
    vectors++;
    if (inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL redir_out_pre: iv %b want 1", inst_valid);
    end
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0203;
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    vectors++;
    if (fetch_cnt !== 32'd0 || inst_valid !== 1'b0 ||
        req_valid !== 1'b1 || req_addr !== 32'h8000_0200) begin
      errors++;
      $display("FAIL redir_out: cnt %0d iv %b rv %b addr %h want 0 0 1 80000200",
               fetch_cnt, inst_valid, req_valid, req_addr);
    end
    idle_inputs();
  endtask

  task automatic test_wrap;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    req_ready      = 1'b1;
    resp_valid     = 1'b1;
    resp_data      = 32'h0000_0033;
    tick();
    tick();
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_pc: iv %b pc %h want 1 fffffffc", inst_valid, inst_pc);
    end
    inst_ready = 1'b1;
    tick();
    vectors++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next: rv %b addr %h want 1 0", req_valid, req_addr);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid;
    do_reset();
    req_ready = 1'b1;
    tick();
    tick();
    inst_ready = 1'b1;
    reset      = 1'b0;
    resp_valid = 1'b1;
    resp_data  = 32'h5555_AAAA;
    tick();
    vectors++;
    if (req_valid !== 1'b0 || inst_valid !== 1'b0 || req_addr !== 32'h0 ||
        inst !== 32'h0 || inst_pc !== 32'h0 || fetch_cnt !== 32'h0) begin
      errors++;
      $display("FAIL mid_rst: rv %b iv %b addr %h inst %h pc %h cnt %h want 0",
               req_valid, inst_valid, req_addr, inst, inst_pc, fetch_cnt);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== RPC) begin
      errors++;
      $display("FAIL mid_rst_req: iv %b rv %b addr %h want 0 1 %h",
               inst_valid, req_valid, req_addr, RPC);
    end
    idle_inputs();
  endtask

  task automatic test_random;
    logic [31:0] exp_next, pend_addr, out_addr, off_addr, off_data;
    logic [31:0] cnt, tgt, r;
    bit pend, pend_stale, outst, out_stale, off, cur_stale, was_out;
    int accepts, idle_run;
    do_reset();
    exp_next   = RPC;
    cnt        = '0;
    pend       = 0;
    pend_stale = 0;
    outst      = 0;
    out_stale  = 0;
    off        = 0;
    pend_addr  = '0;
    out_addr   = '0;
    off_addr   = '0;
    off_data   = '0;
    accepts    = 0;
    idle_run   = 0;
    for (int c = 0; c < 3000; c++) begin
      vectors++;
      if (fetch_cnt !== cnt) begin
        errors++;
        $display("FAIL rnd_cnt @%0d: got %0d want %0d", c, fetch_cnt, cnt);
      end
      vectors++;
      if (pend) begin
        if (req_valid !== 1'b1 || req_addr !== pend_addr) begin
          errors++;
          $display("FAIL rnd_req_hold @%0d: v %b addr %h want 1 %h",
                   c, req_valid, req_addr, pend_addr);
        end
      end else if (req_valid === 1'b1) begin
        if (req_addr !== exp_next || outst || off) begin
          errors++;
          $display("FAIL rnd_req_new @%0d: addr %h want %h busy %b%b",
                   c, req_addr, exp_next, outst, off);
        end
      end
      vectors++;
      if (inst_valid !== off) begin
        errors++;
        $display("FAIL rnd_offer_v @%0d: got %b want %b", c, inst_valid, off);
      end else if (off) begin
        vectors++;
        if (inst !== off_data || inst_pc !== off_addr) begin
          errors++;
          $display("FAIL rnd_offer @%0d: inst %h pc %h want %h %h",
                   c, inst, inst_pc, off_data, off_addr);
        end
      end
      if (req_valid !== 1'b1 && inst_valid !== 1'b1 && !outst) idle_run++;
      else idle_run = 0;
      vectors++;
      if (idle_run > 2) begin
        errors++;
        $display("FAIL rnd_stall @%0d: idle %0d cycles want <=2", c, idle_run);
        idle_run = 0;
      end
      req_ready      = 1'($urandom_range(0, 1));
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      r = $urandom;
      if (r[31:30] == 2'b00) tgt = 32'hFFFF_FFF0 | {28'h0, r[3:0]};
      else tgt = RPC | {20'h0, r[11:0]};
      redirect_pc = tgt;
      if (outst) begin
        resp_valid = ($urandom_range(0, 2) == 0);
        resp_data  = mem_word(out_addr);
      end else begin
        resp_valid = ($urandom_range(0, 3) == 0);
        resp_data  = $urandom;
      end
      was_out   = outst;
      cur_stale = pend ? pend_stale : 1'b0;
      if (redirect_valid) begin
        exp_next  = tgt & 32'hFFFF_FFFC;
        cur_stale = 1;
        if (outst) out_stale = 1;
        off = 0;
      end else if (off && inst_ready) begin
        cnt      = cnt + 32'd1;
        exp_next = off_addr + 32'd4;
        off      = 0;
        accepts++;
      end
      if (was_out && resp_valid) begin
        outst = 0;
        if (!out_stale) begin
          off      = 1;
          off_addr = out_addr;
          off_data = resp_data;
        end
      end
      if (req_valid === 1'b1) begin
        if (req_ready) begin
          outst     = 1;
          out_addr  = req_addr;
          out_stale = cur_stale;
          pend      = 0;
        end else begin
          pend       = 1;
          pend_addr  = req_addr;
          pend_stale = cur_stale;
        end
      end
      tick();
    end
    vectors++;
    if (accepts < 50) begin
      errors++;
      $display("FAIL rnd_progress: accepts %0d want >=50", accepts);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_slow_resp();
    test_backpressure();
    test_redirect_wait();
    test_redirect_out();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
